// File: rtl/image_ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// image_ram_arbiter_if
// Bundles the requester handshakes and the single-port RAM command/return bus
// of the image RAM arbiter.
//   slave  modport : arbiter side (consumes requests and RAM read data, drives
//                    grants, read returns and the registered RAM command)
//   master modport : requester / RAM side (drives requests and RAM read data)
// Signals:
//   vga_req/vga_addr                       VGA fetch request and read address
//   vga_gnt/vga_rvalid/vga_rdata           VGA grant pulse and read return
//   cpu_req/cpu_we/cpu_addr/cpu_wdata      CPU access request
//   cpu_gnt/cpu_rvalid/cpu_rdata           CPU grant pulse and read return
//   ram_addr/ram_we/ram_wd                 registered RAM command
//   ram_rd                                 synchronous RAM read data
// -----------------------------------------------------------------------------
interface image_ram_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic              vga_gnt;
   logic              vga_rvalid;
   logic [DATA_W-1:0] vga_rdata;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wd;
   logic [DATA_W-1:0] ram_rd;

   modport slave (
      input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rd,
      output vga_gnt, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
             ram_addr, ram_we, ram_wd
   );

   modport master (
      output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rd,
      input  vga_gnt, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
             ram_addr, ram_we, ram_wd
   );
endinterface

// File: rtl/image_ram_arbiter.sv
// -----------------------------------------------------------------------------
// image_ram_arbiter
// Shares the single-port image RAM between the VGA pixel fetcher (priority)
// and the CPU load/store path. A run counter forces one CPU slot after
// MAX_VGA_RUN consecutive VGA grants while the CPU waits. The winning command
// is registered onto the RAM bus and a one-bit owner tag follows each read
// through the RAM latency so only the owner sees rvalid.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  image_ram_arbiter_if.slave (requests, grants, returns, RAM bus)
// -----------------------------------------------------------------------------
module image_ram_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int MAX_VGA_RUN = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   image_ram_arbiter_if.slave    bus
);

   typedef enum logic {
      VGA_PRI  = 1'b0,
      CPU_SLOT = 1'b1
   } state_t;

   localparam logic [3:0] RUN_MAX = 4'(MAX_VGA_RUN);

   state_t            state_q;
   logic [3:0]        run_q;
   logic [3:0]        run_d;
   logic              vga_win;
   logic              cpu_win;

   logic [ADDR_W-1:0] ram_addr_q;
   logic              ram_we_q;
   logic [DATA_W-1:0] ram_wd_q;

   // owner tag: 1 = CPU, 0 = VGA
   logic              tag_vld_p0;
   logic              tag_cpu_p0;
   logic              tag_vld_p1;
   logic              tag_cpu_p1;

   // Grant decision; nothing is granted while reset is held.
   always_comb begin
      vga_win = 1'b0;
      cpu_win = 1'b0;
      if (!rst) begin
         if (state_q == VGA_PRI) begin
            if (bus.vga_req)      vga_win = 1'b1;
            else if (bus.cpu_req) cpu_win = 1'b1;
         end else begin
            if (bus.cpu_req)      cpu_win = 1'b1;
            else if (bus.vga_req) vga_win = 1'b1;
         end
      end
   end

   // Run length only counts VGA grants that actually made the CPU wait.
   always_comb begin
      run_d = run_q;
      if (!bus.cpu_req || cpu_win) run_d = 4'd0;
      else if (vga_win)            run_d = run_q + 4'd1;
   end

   // Stage p0: registered RAM command and owner tag of the issued read
   // Stage p1: tag aligned with ram_rd
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= VGA_PRI;
         run_q      <= 4'd0;
         ram_addr_q <= '0;
         ram_we_q   <= 1'b0;
         ram_wd_q   <= '0;
         tag_vld_p0 <= 1'b0;
         tag_cpu_p0 <= 1'b0;
         tag_vld_p1 <= 1'b0;
         tag_cpu_p1 <= 1'b0;
      end else begin
         run_q <= run_d;
         case (state_q)
            VGA_PRI:  if (run_d == RUN_MAX) state_q <= CPU_SLOT;
            CPU_SLOT: state_q <= VGA_PRI;
            default:  state_q <= VGA_PRI;
         endcase

         ram_we_q <= cpu_win & bus.cpu_we;
         if (vga_win) begin
            ram_addr_q <= bus.vga_addr;
         end else if (cpu_win) begin
            ram_addr_q <= bus.cpu_addr;
            ram_wd_q   <= bus.cpu_wdata;
         end

         tag_vld_p0 <= vga_win | (cpu_win & ~bus.cpu_we);
         tag_cpu_p0 <= cpu_win;
         tag_vld_p1 <= tag_vld_p0;
         tag_cpu_p1 <= tag_cpu_p0;
      end
   end

   assign bus.vga_gnt    = vga_win;
   assign bus.cpu_gnt    = cpu_win;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.ram_wd     = ram_wd_q;
   assign bus.vga_rvalid = tag_vld_p1 & ~tag_cpu_p1;
   assign bus.cpu_rvalid = tag_vld_p1 &  tag_cpu_p1;
   assign bus.vga_rdata  = bus.ram_rd;
   assign bus.cpu_rdata  = bus.ram_rd;

endmodule

// File: tb/tb_image_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_image_ram_arbiter
// Directed bench for image_ram_arbiter: a vector table of per-cycle requests
// and expected grants, with RAM command and read-return expectations derived
// from the table rows one and two cycles earlier, plus hand-written reset
// sequences. Includes a small synchronous RAM model.
// -----------------------------------------------------------------------------
module tb_image_ram_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   image_ram_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

   image_ram_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_VGA_RUN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] ramval(logic [15:0] a);
      return {a ^ 16'h5A5A, ~a};
   endfunction

   // synchronous RAM model, unwritten words return ramval(addr)
   logic [31:0]   mem [0:1023];
   logic [1023:0] wr_flag;
   always @(posedge clk) begin
      if (rst) wr_flag <= '0;
      else if (bus.ram_we) begin
         mem[bus.ram_addr[9:0]]     <= bus.ram_wd;
         wr_flag[bus.ram_addr[9:0]] <= 1'b1;
      end
      bus.ram_rd <= wr_flag[bus.ram_addr[9:0]] ? mem[bus.ram_addr[9:0]]
                                               : ramval({6'd0, bus.ram_addr[9:0]});
   end

   logic [31:0] shadow [logic [15:0]];
   function automatic logic [31:0] rdval(logic [15:0] a);
      if (shadow.exists(a)) return shadow[a];
      return ramval(a);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        vr;
      logic [15:0] va;
      logic        cr;
      logic        cw;
      logic [15:0] ca;
      logic [31:0] cd;
      logic        ev;
      logic        ec;
   } vec_t;

   function automatic vec_t mk(logic vr, logic [15:0] va, logic cr, logic cw,
                               logic [15:0] ca, logic [31:0] cd, logic ev, logic ec);
      vec_t v;
      v.vr = vr; v.va = va; v.cr = cr; v.cw = cw;
      v.ca = ca; v.cd = cd; v.ev = ev; v.ec = ec;
      return v;
   endfunction

   task automatic drive(input logic vr, input logic [15:0] va, input logic cr,
                        input logic cw, input logic [15:0] ca, input logic [31:0] cd);
      bus.vga_req   = vr;
      bus.vga_addr  = va;
      bus.cpu_req   = cr;
      bus.cpu_we    = cw;
      bus.cpu_addr  = ca;
      bus.cpu_wdata = cd;
   endtask

   vec_t        tbl [$];
   logic [31:0] exp_data [$];
   vec_t        pv;
   logic [15:0] exp_addr;
   logic        exp_we, exp_vv, exp_cv;

   initial begin
      // ---------------- reset with both requests high ----------------
      drive(1'b1, 16'h0044, 1'b1, 1'b1, 16'h0055, 32'h1);
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_vga_gnt", {31'd0, bus.vga_gnt}, 32'd0);
         chk("rst_cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd0);
         chk("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
         chk("rst_ram_addr", {16'd0, bus.ram_addr}, 32'd0);
         chk("rst_vga_rvalid", {31'd0, bus.vga_rvalid}, 32'd0);
         chk("rst_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
      @(negedge clk);
      chk("rel_vga_rvalid", {31'd0, bus.vga_rvalid}, 32'd0);
      chk("rel_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
      chk("rel_ram_wd", bus.ram_wd, 32'd0);

      // ---------------- vector table ----------------
      tbl.push_back(mk(0, 16'h0, 1, 1, 16'h0010, 32'hDEADBEEF, 0, 1)); // 0 cpu write
      tbl.push_back(mk(0, 16'h0, 0, 0, 16'h0, 32'h0, 0, 0));
      tbl.push_back(mk(0, 16'h0, 1, 0, 16'h0010, 32'h0, 0, 1));        // 2 cpu read back
      tbl.push_back(mk(0, 16'h0, 0, 0, 16'h0, 32'h0, 0, 0));
      tbl.push_back(mk(0, 16'h0, 0, 0, 16'h0, 32'h0, 0, 0));
      tbl.push_back(mk(1, 16'h0100, 0, 0, 16'h0, 32'h0, 1, 0));        // 5 interleaved
      tbl.push_back(mk(0, 16'h0, 1, 0, 16'h0200, 32'h0, 0, 1));
      tbl.push_back(mk(0, 16'h0, 0, 0, 16'h0, 32'h0, 0, 0));
      tbl.push_back(mk(0, 16'h0, 0, 0, 16'h0, 32'h0, 0, 0));
      for (int i = 0; i < 10; i++)                                      // 9..18 starvation guard
         tbl.push_back(mk(1, 16'h0300 + 16'(i), 1, 0, 16'h0200, 32'h0,
                          (i % 5) != 4, (i % 5) == 4));
      tbl.push_back(mk(0, 16'h0, 0, 0, 16'h0, 32'h0, 0, 0));
      tbl.push_back(mk(1, 16'h0180, 0, 0, 16'h0, 32'h0, 1, 0));        // 20 withdrawal
      tbl.push_back(mk(1, 16'h0181, 1, 0, 16'h0204, 32'h0, 1, 0));
      tbl.push_back(mk(1, 16'h0182, 0, 0, 16'h0, 32'h0, 1, 0));
      tbl.push_back(mk(1, 16'h0183, 0, 0, 16'h0, 32'h0, 1, 0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1, 16'h0184 + 16'(i), 1, 0, 16'h0208, 32'h0, 1, 0));
      tbl.push_back(mk(1, 16'h0188, 1, 0, 16'h0208, 32'h0, 0, 1));     // 28 CPU slot
      tbl.push_back(mk(0, 16'h0, 0, 0, 16'h0, 32'h0, 0, 0));
      tbl.push_back(mk(0, 16'h0, 0, 0, 16'h0, 32'h0, 0, 0));

      exp_addr = 16'h0;
      for (int k = 0; k < tbl.size(); k++) begin
         @(posedge clk); #1;
         drive(tbl[k].vr, tbl[k].va, tbl[k].cr, tbl[k].cw, tbl[k].ca, tbl[k].cd);
         if (tbl[k].ev)      exp_data.push_back(rdval(tbl[k].va));
         else                exp_data.push_back(rdval(tbl[k].ca));
         if (tbl[k].ec && tbl[k].cw) shadow[tbl[k].ca] = tbl[k].cd;
         @(negedge clk);
         chk($sformatf("vga_gnt[%0d]", k), {31'd0, bus.vga_gnt}, {31'd0, tbl[k].ev});
         chk($sformatf("cpu_gnt[%0d]", k), {31'd0, bus.cpu_gnt}, {31'd0, tbl[k].ec});

         exp_we = 1'b0;
         if (k >= 1) begin
            pv = tbl[k-1];
            if (pv.ev)      exp_addr = pv.va;
            else if (pv.ec) exp_addr = pv.ca;
            exp_we = pv.ec & pv.cw;
            if (exp_we) chk($sformatf("ram_wd[%0d]", k), bus.ram_wd, pv.cd);
         end
         chk($sformatf("ram_we[%0d]", k), {31'd0, bus.ram_we}, {31'd0, exp_we});
         chk($sformatf("ram_addr[%0d]", k), {16'd0, bus.ram_addr}, {16'd0, exp_addr});

         exp_vv = 1'b0;
         exp_cv = 1'b0;
         if (k >= 2) begin
            exp_vv = tbl[k-2].ev;
            exp_cv = tbl[k-2].ec & ~tbl[k-2].cw;
         end
         chk($sformatf("vga_rvalid[%0d]", k), {31'd0, bus.vga_rvalid}, {31'd0, exp_vv});
         chk($sformatf("cpu_rvalid[%0d]", k), {31'd0, bus.cpu_rvalid}, {31'd0, exp_cv});
         if (exp_vv) chk($sformatf("vga_rdata[%0d]", k), bus.vga_rdata, exp_data[k-2]);
         if (exp_cv) chk($sformatf("cpu_rdata[%0d]", k), bus.cpu_rdata, exp_data[k-2]);
      end

      // ---------------- write aborted by reset ----------------
      @(posedge clk); #1;
      drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 32'h12345678);
      @(negedge clk);
      chk("abort_cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
      @(negedge clk);
      chk("abort_we_before", {31'd0, bus.ram_we}, 32'd1);
      chk("abort_addr_before", {16'd0, bus.ram_addr}, 32'h0020);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_we_after", {31'd0, bus.ram_we}, 32'd0);
      chk("abort_addr_after", {16'd0, bus.ram_addr}, 32'd0);

      // ---------------- reset mid-read from CPU_SLOT-bound state ----------------
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         drive(1'b1, 16'h0040 + 16'(c), 1'b1, 1'b0, 16'h0050, 32'h0);
         @(negedge clk);
         chk($sformatf("mid_vga_gnt[%0d]", c), {31'd0, bus.vga_gnt}, 32'd1);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
      @(negedge clk);
      chk("mid_rst_vga_gnt", {31'd0, bus.vga_gnt}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b1, 16'h0060, 1'b1, 1'b0, 16'h0070, 32'h0);
      @(negedge clk);
      chk("mid_vga_rvalid", {31'd0, bus.vga_rvalid}, 32'd0);
      chk("mid_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
      chk("mid_state_vga_gnt", {31'd0, bus.vga_gnt}, 32'd1);
      chk("mid_state_cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd0);
      @(posedge clk); #1;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
